// File: rtl/skew_fifo_bank.sv
// Multi-lane circular FIFO bank that feeds one edge of the systolic array.
// Lane i starts each pass with i*SKEW zero pad words to diagonalise a common read.
module skew_fifo_bank #(
  parameter int WORDLEN = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int SKEW = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     restart,
  input  logic [LANES-1:0]         wr_en,
  input  logic [LANES*WORDLEN-1:0] din,
  input  logic                     rd_en,
  output logic [LANES*WORDLEN-1:0] dout,
  output logic [LANES-1:0]         empty,
  output logic [LANES-1:0]         full,
  output logic [LANES*CW-1:0]      count,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [LANES-1:0] drop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [CW-1:0] PAD0 = CW'(i * SKEW);

    logic [WORDLEN-1:0] mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      stored;
    logic [CW-1:0]      pad_cnt;
    logic [CW-1:0]      cnt;
    logic [WORDLEN-1:0] wdata;
    logic               rd_pad;
    logic               rd_dat;
    logic               wr_ok;

    assign wdata  = din[i*WORDLEN +: WORDLEN];
    assign cnt    = pad_cnt + stored;
    assign rd_pad = rd_en && (pad_cnt != '0);
    assign rd_dat = rd_en && (pad_cnt == '0) && (stored != '0);
    // A full lane is never empty, so a same-cycle read always frees a slot
    assign wr_ok  = wr_en[i] && ((cnt != CW'(DEPTH)) || rd_en);
    assign drop[i] = wr_en[i] && !wr_ok;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        head    <= '0;
        tail    <= '0;
        stored  <= '0;
        pad_cnt <= PAD0;
      end else if (restart) begin
        head    <= '0;
        tail    <= '0;
        stored  <= '0;
        pad_cnt <= PAD0;
      end else begin
        if (rd_pad) pad_cnt <= pad_cnt - CW'(1);
        if (rd_dat) head <= nxt(head);
        if (wr_ok) tail <= nxt(tail);
        unique case ({wr_ok, rd_dat})
          2'b10:   stored <= stored + CW'(1);
          2'b01:   stored <= stored - CW'(1);
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (wr_ok && !restart) mem[tail] <= wdata;
    end

    assign dout[i*WORDLEN +: WORDLEN] =
      ((pad_cnt != '0) || (stored == '0)) ? '0 : mem[head];
    assign count[i*CW +: CW] = cnt;
    assign empty[i] = (cnt == '0);
    assign full[i]  = (cnt == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
    end else if (restart) begin
      ovf_err <= 1'b0;
    end else if (|drop) begin
      ovf_err <= 1'b1;
    end
  end

endmodule
